// File: rtl/seq_det_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_det_sched_pkg
// Brief  : Shared state encoding and constants for the seq_det scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package seq_det_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int          FRAME_BITS = 8;
    // Pattern recognised by the external detector; the scheduler never uses it.
    localparam logic [3:0]  PATTERN    = 4'b1011;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter with a last-served register.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    // 1 means R1 was served last, so R0 wins the first tie after reset
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update && (|i_req)) begin
            r_last <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module : seq_det_sched
// Brief  : Serialises arbitrated 8-bit frames into an external "1011"
//          detector and reports the number of hits per frame.
// Rev    : 1.0  initial release
// ============================================================================
module seq_det_sched
    import seq_det_sched_pkg::*;
#(
    parameter int FRAME_BITS = seq_det_sched_pkg::FRAME_BITS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] match_cnt,
    output logic       busy,
    output logic       det_din,
    output logic       det_rst,
    input  logic       det_dout
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      w_grant;
    logic            w_arb_update;
    logic            w_last_bit;
    logic            r_id;
    logic [7:0]      r_shreg;
    logic [CW-1:0]   r_bit_cnt;
    logic [1:0]      r_hit;
    logic [1:0]      r_match_hold;

    assign w_arb_update = (r_state == ST_IDLE) && (|req);
    assign w_last_bit   = (r_bit_cnt == CW'(FRAME_BITS - 1));

    rr_arb2 u_arb (
        .clk      (clock),
        .rst      (reset),
        .i_req    (req),
        .i_update (w_arb_update),
        .o_grant  (w_grant)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|req) w_next = ST_CLR;
            ST_CLR:   w_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id         <= 1'b0;
            r_shreg      <= 8'h00;
            r_bit_cnt    <= '0;
            r_hit        <= 2'd0;
            r_match_hold <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_id    <= w_grant[1];
                        r_shreg <= w_grant[1] ? data1 : data0;
                    end
                end
                ST_CLR: begin
                    r_bit_cnt <= '0;
                    r_hit     <= 2'd0;
                end
                ST_SHIFT: begin
                    r_shreg   <= {r_shreg[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    // The detector output in the first bit slot still reflects the cleared state
                    if (det_dout && (r_bit_cnt != '0) && (r_hit != 2'd3)) begin
                        r_hit <= r_hit + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (det_dout && (r_hit != 2'd3)) begin
                        r_hit <= r_hit + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_match_hold <= r_hit;
                end
                default: begin
                    r_hit <= r_hit;
                end
            endcase
        end
    end

    always_comb begin
        gnt       = 2'b00;
        done      = 2'b00;
        if (r_state == ST_CLR) begin
            gnt = r_id ? 2'b10 : 2'b01;
        end
        if (r_state == ST_DONE) begin
            done = r_id ? 2'b10 : 2'b01;
        end
        match_cnt = (r_state == ST_DONE) ? r_hit : r_match_hold;
        busy      = (r_state != ST_IDLE);
        det_din   = (r_state == ST_SHIFT) && r_shreg[7];
        det_rst   = reset || (r_state == ST_CLR);
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_det_sched
// Brief  : Directed self-checking bench; includes a behavioural 1011 detector.
// Rev    : 1.0  initial release
// ============================================================================
module tb_seq_det_sched;
    import seq_det_sched_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req   = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [1:0] gnt, done, match_cnt;
    logic       busy, det_din, det_rst, det_dout;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    seq_det_sched dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .done      (done),
        .match_cnt (match_cnt),
        .busy      (busy),
        .det_din   (det_din),
        .det_rst   (det_rst),
        .det_dout  (det_dout)
    );

    // Overlapping Moore detector for 1011; state 4 = pattern just seen
    logic [2:0] det_st;
    always @(posedge clock) begin
        if (det_rst) det_st <= 3'd0;
        else begin
            case (det_st)
                3'd0:    det_st <= det_din ? 3'd1 : 3'd0;
                3'd1:    det_st <= det_din ? 3'd1 : 3'd2;
                3'd2:    det_st <= det_din ? 3'd3 : 3'd0;
                3'd3:    det_st <= det_din ? 3'd4 : 3'd2;
                default: det_st <= det_din ? 3'd1 : 3'd2;
            endcase
        end
    end
    assign det_dout = (det_st == 3'd4);

    always @(negedge clock) begin
        if (!reset) begin
            total++;
            if (!$onehot0(gnt)) begin bad++; $display("FAIL onehot_gnt: got %b", gnt); end
            total++;
            if (!$onehot0(done)) begin bad++; $display("FAIL onehot_done: got %b", done); end
            total++;
            if (busy !== (dut.r_state != ST_IDLE)) begin
                bad++; $display("FAIL busy_state: busy %b state %0d", busy, dut.r_state);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1);
    end

    task automatic test_reset;
        @(negedge clock);
        total++; if (gnt !== 2'b00)       begin bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        total++; if (done !== 2'b00)      begin bad++; $display("FAIL rst_done: got %b want 00", done); end
        total++; if (match_cnt !== 2'd0)  begin bad++; $display("FAIL rst_match: got %0d want 0", match_cnt); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (det_din !== 1'b0)    begin bad++; $display("FAIL rst_din: got %b want 0", det_din); end
        total++; if (det_rst !== 1'b1)    begin bad++; $display("FAIL rst_detrst: got %b want 1", det_rst); end
        reset = 1'b0;
    endtask

    task automatic test_r0_basic;
        logic [7:0] bits;
        @(negedge clock);
        data0 = 8'b1011_0110; req = 2'b01;
        @(negedge clock);
        total++; if (gnt !== 2'b01)    begin bad++; $display("FAIL r0_gnt: got %b want 01", gnt); end
        total++; if (det_rst !== 1'b1) begin bad++; $display("FAIL r0_detrst_clr: got %b want 1", det_rst); end
        req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            bits[7-k] = det_din;
        end
        total++; if (bits !== 8'b1011_0110) begin bad++; $display("FAIL r0_serial: got %b want 10110110", bits); end
        @(negedge clock);
        total++; if (det_din !== 1'b0 || done !== 2'b00) begin
            bad++; $display("FAIL r0_drain: din %b done %b want 0 00", det_din, done);
        end
        @(negedge clock);
        total++; if (done !== 2'b01)     begin bad++; $display("FAIL r0_done: got %b want 01", done); end
        total++; if (match_cnt !== 2'd2) begin bad++; $display("FAIL r0_count: got %0d want 2", match_cnt); end
        @(negedge clock);
        total++; if (done !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL r0_idle: done %b busy %b want 00 0", done, busy);
        end
        total++; if (match_cnt !== 2'd2) begin bad++; $display("FAIL r0_hold: got %0d want 2", match_cnt); end
    endtask

    task automatic test_r1_zero;
        logic [7:0] bits;
        @(negedge clock);
        data1 = 8'h00; req = 2'b10;
        @(negedge clock);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL r1_gnt: got %b want 10", gnt); end
        req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            bits[7-k] = det_din;
        end
        total++; if (bits !== 8'h00) begin bad++; $display("FAIL r1_serial: got %b want 00000000", bits); end
        @(negedge clock);
        @(negedge clock);
        total++; if (done !== 2'b10)     begin bad++; $display("FAIL r1_done: got %b want 10", done); end
        total++; if (match_cnt !== 2'd0) begin bad++; $display("FAIL r1_count: got %0d want 0", match_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_g [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        @(negedge clock);
        reset = 1'b1; req = 2'b11; data0 = 8'b0000_1011; data1 = 8'b1101_1000;
        @(negedge clock);
        reset = 1'b0;
        for (int f = 0; f < 3; f++) begin
            @(negedge clock);
            total++; if (gnt !== exp_g[f]) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", f, gnt, exp_g[f]); end
            repeat (9) @(negedge clock);
            @(negedge clock);
            total++; if (done !== exp_g[f]) begin bad++; $display("FAIL b2b_done%0d: got %b want %b", f, done, exp_g[f]); end
            total++; if (match_cnt !== 2'd1) begin bad++; $display("FAIL b2b_count%0d: got %0d want 1", f, match_cnt); end
            @(negedge clock);
            total++; if (busy !== 1'b0 || gnt !== 2'b00) begin
                bad++; $display("FAIL b2b_idle%0d: busy %b gnt %b want 0 00", f, busy, gnt);
            end
            if (f == 2) req = 2'b00;
        end
    endtask

    task automatic test_reset_midframe;
        logic seen_done;
        @(negedge clock);
        data0 = 8'b1011_0110; req = 2'b01;
        @(negedge clock);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_gnt: got %b want 01", gnt); end
        req = 2'b00;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin
            bad++; $display("FAIL mid_rst_ctl: busy %b gnt %b done %b want 0 00 00", busy, gnt, done);
        end
        total++; if (match_cnt !== 2'd0) begin bad++; $display("FAIL mid_rst_match: got %0d want 0", match_cnt); end
        total++; if (det_din !== 1'b0 || det_rst !== 1'b1) begin
            bad++; $display("FAIL mid_rst_det: din %b rst %b want 0 1", det_din, det_rst);
        end
        @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (done !== 2'b00) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL mid_no_done: got %b want 0", seen_done); end
        data0 = 8'b0000_1011; req = 2'b01;
        @(negedge clock);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_regnt: got %b want 01", gnt); end
        req = 2'b00;
        repeat (9) @(negedge clock);
        @(negedge clock);
        total++; if (done !== 2'b01 || match_cnt !== 2'd1) begin
            bad++; $display("FAIL mid_redone: done %b cnt %0d want 01 1", done, match_cnt);
        end
    endtask

    task automatic test_tail_hit;
        @(negedge clock);
        data0 = 8'b1011_1011; req = 2'b01;
        @(negedge clock);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL tail_gnt: got %b want 01", gnt); end
        req = 2'b00;
        repeat (9) @(negedge clock);
        @(negedge clock);
        total++; if (done !== 2'b01)     begin bad++; $display("FAIL tail_done: got %b want 01", done); end
        total++; if (match_cnt !== 2'd2) begin bad++; $display("FAIL tail_count: got %0d want 2", match_cnt); end
    endtask

    initial begin
        test_reset();
        test_r0_basic();
        test_r1_zero();
        test_back_to_back();
        test_reset_midframe();
        test_tail_hit();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
